bcd_to_binary: RTL and testbench

Registered BCD-to-binary converter for the stopwatch display/arithmetic path. Converts one BCD digit, or optionally a tens/ones digit pair, into an unsigned 7-bit binary value in the range 0..99. Flags and clamps illegal BCD codes. Sits between the stopwatch BCD counters and any logic that needs plain binary, such as comparators and the LED bar.

---
 rtl/bcd_to_binary.sv | 70 +++++++
 tb/tb_bcd_to_binary.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Registered BCD-to-binary converter: clamps illegal digits to 9 and flags them.
// Define BCD_TENS_EN to add a tens digit (bin = tens*10 + ones); otherwise ones digit only.
module bcd_to_binary (
    input  logic       clk,
    input  logic       rst,
`ifdef BCD_TENS_EN
    input  logic [3:0] bcd_tens,
`endif
    input  logic [3:0] bcd,
    output logic [6:0] bin,
    output logic       invalid
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BIN_W   = 7;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

    logic               ones_bad;
    logic [DIGIT_W-1:0] ones_cl;
    logic [BIN_W-1:0]   bin_nxt;
    logic               invalid_nxt;

`ifdef BCD_TENS_EN
    logic               tens_bad;
    logic [DIGIT_W-1:0] tens_cl;
    logic [BIN_W-1:0]   tens_w;

    // Clamp the tens digit; x10 as (t<<3)+(t<<1) fits in 7 bits since the max is 99
    always_comb begin
        tens_bad = 1'b0;
        tens_cl  = bcd_tens;
        tens_w   = '0;
        if (bcd_tens > DIGIT_MAX) begin
            tens_bad = 1'b1;
            tens_cl  = DIGIT_MAX;
        end
        tens_w = BIN_W'(tens_cl);
    end
`endif

    // Clamp the ones digit and form the next result
    always_comb begin
        ones_bad    = 1'b0;
        ones_cl     = bcd;
        bin_nxt     = '0;
        invalid_nxt = 1'b0;
        if (bcd > DIGIT_MAX) begin
            ones_bad = 1'b1;
            ones_cl  = DIGIT_MAX;
        end
`ifdef BCD_TENS_EN
        bin_nxt     = (tens_w << 3) + (tens_w << 1) + BIN_W'(ones_cl);
        invalid_nxt = ones_bad | tens_bad;
`else
        bin_nxt     = BIN_W'(ones_cl);
        invalid_nxt = ones_bad;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin     <= '0;
            invalid <= 1'b0;
        end else begin
            bin     <= bin_nxt;
            invalid <= invalid_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary; exercises the tens path when BCD_TENS_EN is defined.
module tb_bcd_to_binary;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd;
    logic [3:0] bcd_tens;
    logic [6:0] bin;
    logic       invalid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_to_binary dut (
        .clk      (clk),
        .rst      (rst),
`ifdef BCD_TENS_EN
        .bcd_tens (bcd_tens),
`endif
        .bcd      (bcd),
        .bin      (bin),
        .invalid  (invalid)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        bcd      = 4'd7;
        bcd_tens = 4'd0;

        // Reset is visible before any clock edge
        #2;
        check("rst_bin", int'(bin), 0);
        check("rst_inv", int'(invalid), 0);
        #1 rst = 1'b0;
        step();
        check("post_rst_bin", int'(bin), 7);
        check("post_rst_inv", int'(invalid), 0);

        for (int d = 0; d < 10; d++) begin
            bcd = 4'(d);
            step();
            check("sweep_bin", int'(bin), d);
            check("sweep_inv", int'(invalid), 0);
        end

        for (int d = 10; d < 16; d++) begin
            bcd = 4'(d);
            step();
            check("illegal_bin", int'(bin), 9);
            check("illegal_inv", int'(invalid), 1);
        end

        bcd = 4'd3;
        step();
        check("recover_bin", int'(bin), 3);
        check("recover_inv", int'(invalid), 0);

        // Input change between edges must not reach the outputs
        bcd = 4'd6;
        #2;
        check("hold_bin", int'(bin), 3);
        step();
        check("hold_next_bin", int'(bin), 6);

        // Mid-stream reset
        bcd = 4'd5;
        step();
        check("mid_pre_bin", int'(bin), 5);
        rst = 1'b1;
        #1;
        check("mid_rst_bin", int'(bin), 0);
        bcd = 4'd8;
        #1 rst = 1'b0;
        step();
        check("mid_post_bin", int'(bin), 8);

        bcd = 4'd12;
        step();
        check("mid_inv_set", int'(invalid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_inv", int'(invalid), 0);
        check("mid_rst_bin2", int'(bin), 0);
        bcd = 4'd1;
        #1 rst = 1'b0;
        step();
        check("mid_post_bin2", int'(bin), 1);
        check("mid_post_inv2", int'(invalid), 0);

`ifdef BCD_TENS_EN
        bcd_tens = 4'd0; bcd = 4'd0; step();
        check("tens_0_0", int'(bin), 0);
        bcd_tens = 4'd5; bcd = 4'd9; step();
        check("tens_5_9", int'(bin), 59);
        bcd_tens = 4'd9; bcd = 4'd9; step();
        check("tens_9_9", int'(bin), 99);
        check("tens_9_9_inv", int'(invalid), 0);
        bcd_tens = 4'd1; bcd = 4'd0; step();
        check("tens_1_0", int'(bin), 10);
        bcd_tens = 4'd12; bcd = 4'd4; step();
        check("tens_12_4", int'(bin), 94);
        check("tens_12_4_inv", int'(invalid), 1);
        bcd_tens = 4'd3; bcd = 4'd15; step();
        check("tens_3_15", int'(bin), 39);
        check("tens_3_15_inv", int'(invalid), 1);
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                bcd_tens = 4'(t);
                bcd      = 4'(o);
                step();
                check("pair_bin", int'(bin), t * 10 + o);
                check("pair_inv", int'(invalid), 0);
            end
        end
`else
        // Upper bits stay zero even for the clamped maximum
        bcd = 4'd15;
        step();
        check("upper_zero", int'(bin[6:4]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
